// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch constants: datapath width, instruction width, reset PC and bubble encoding.
package legv8_pkg;
  localparam int N_DEF = 64;
  localparam int INSTR_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [N_DEF-1:0] PC_RESET = '0;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0;
endpackage

// File: rtl/fetch_ifid_flopre.sv
// Synchronous-reset register with clear and enable; priority reset > clear > enable.
module flopre #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= RESET_VAL;
    end else if (clr_i) begin
      q_q <= CLEAR_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/fetch_ifid.sv
// LEGv8 fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Instruction memory is external and combinational; IF/ID outputs are purely registered.
module fetch_ifid
  import legv8_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int IMEM_AW = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc,
  input  logic [N-1:0]       PCBranch,
  input  logic               stall,
  input  logic               flush,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  output logic [N-1:0]       PC_F,
  output logic [INSTR_W-1:0] instr_D,
  output logic [N-1:0]       pc_D,
  output logic               valid_D
);
  localparam int IFID_W = N + INSTR_W + 1;

  logic [N-1:0]      pc_q;
  logic [N-1:0]      pc_d;
  logic              pc_en;
  logic [IFID_W-1:0] ifid_d;
  logic [IFID_W-1:0] ifid_q;
  logic              unused_branch_lsbs;

  // A taken branch must redirect even while the hazard unit stalls fetch.
  always_comb begin
    pc_d  = pc_q + N'(INSTR_BYTES);
    pc_en = ~stall;
    if (PCSrc) begin
      pc_d  = {PCBranch[N-1:2], 2'b00};
      pc_en = 1'b1;
    end
  end

  assign unused_branch_lsbs = ^PCBranch[1:0];

  flopre #(
    .WIDTH     (N),
    .RESET_VAL (N'(PC_RESET)),
    .CLEAR_VAL ('0)
  ) u_pc (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (pc_en),
    .clr_i   (1'b0),
    .d_i     (pc_d),
    .q_o     (pc_q)
  );

  assign ifid_d = {1'b1, pc_q, imem_q};

  flopre #(
    .WIDTH     (IFID_W),
    .RESET_VAL ({1'b0, {N{1'b0}}, BUBBLE_INSTR}),
    .CLEAR_VAL ({1'b0, {N{1'b0}}, BUBBLE_INSTR})
  ) u_ifid (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (~stall),
    .clr_i   (flush),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  // Upper PC bits are dropped, so fetch addresses alias modulo the memory size.
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign PC_F      = pc_q;
  assign instr_D   = ifid_q[INSTR_W-1:0];
  assign pc_D      = ifid_q[INSTR_W +: N];
  assign valid_D   = ifid_q[IFID_W-1];
endmodule
